tsmac_tx_fifo_reader: RTL
=========================

TSMAC_TX_FIFO_READER -- requirements
Module: tsmac_tx_fifo_reader

Interface
REQ-001: Parameter IFG_CYCLES, default 12, sets the inter-frame gap length in clocks (legal 2..255).
REQ-002: Parameter PREAMBLE_LEN, default 7, sets the number of 0x55 preamble bytes before the SFD (legal 1..15).
REQ-003: tx_clk, input, 1 bit, the single clock for all logic.
REQ-004: tx_rst, input, 1 bit, the reset; it SHALL be synchronous and active-high.
REQ-005: rd_data, input, 10 bits, the TX FIFO head word: [9] eof, [8] err, [7:0] byte.
REQ-006: rd_empty, input, 1 bit, the TX FIFO empty flag.
REQ-007: rd_en, output, 1 bit, pops the FIFO head word (show-ahead: rd_data is valid while rd_empty=0).
REQ-008: gmii_txd, output, 8 bits, the transmit byte.
REQ-009: gmii_tx_en, output, 1 bit, transmit enable.
REQ-010: gmii_tx_er, output, 1 bit, transmit error.
REQ-011: tx_busy, output, 1 bit, high in every state except IDLE.
REQ-012: tx_frame_cnt, output, 16 bits, count of completed frames; wraps.
REQ-013: tx_underrun_cnt, output, 16 bits, count of underruns; saturates at 0xFFFF.

Function
REQ-014: State machine states SHALL be IDLE, PRE, DATA, DRAIN and IFG; all GMII outputs are registered.
REQ-015: rd_en SHALL never be high while rd_empty=1; every pop consumes exactly one word.
REQ-016: IDLE with rd_empty=0 SHALL start a frame; IDLE with rd_empty=1 keeps the GMII outputs at 0.
REQ-017: PRE SHALL drive PREAMBLE_LEN bytes of 0x55 then one byte of 0xD5, with gmii_tx_en=1, gmii_tx_er=0 and rd_en=0.
REQ-018: The first payload pop SHALL occur in the cycle that registers the byte following the SFD, so there is no gap after the SFD.
REQ-019: DATA with rd_empty=0 SHALL pop and register gmii_txd=rd_data[7:0], gmii_tx_en=1 and gmii_tx_er=rd_data[8]; latency from pop to pin is 1 clock.
REQ-020: A DATA pop with eof=1 SHALL increment tx_frame_cnt and transition to IFG.
REQ-021: DATA with rd_empty=1 is an underrun: register gmii_txd=0x00, gmii_tx_en=1 and gmii_tx_er=1 for one clock, increment tx_underrun_cnt, and go to DRAIN.
REQ-022: DRAIN SHALL hold the GMII outputs idle (all 0), pop while rd_empty=0, and go to IFG on popping an eof word; tx_frame_cnt is not incremented.
REQ-023: IFG SHALL hold gmii_tx_en=0 such that exactly IFG_CYCLES low cycles separate two frames when the next frame is already queued; it then returns to IDLE.
REQ-024: A single-word frame (eof on the first payload word) SHALL be legal and produce one payload byte.
REQ-025: An err bit on any word SHALL affect gmii_tx_er for that byte only; framing continues.
REQ-026: rd_empty rising in the same cycle as an eof pop is not an underrun.

Reset
REQ-027: tx_rst=1 at a clock edge SHALL set state IDLE, rd_en=0, gmii_txd=0x00, gmii_tx_en=0, gmii_tx_er=0, tx_busy=0, tx_frame_cnt=0 and tx_underrun_cnt=0.
REQ-028: Reset mid-frame SHALL drop gmii_tx_en at the next edge.
REQ-029: The block does not flush the FIFO; after reset, the next head word is treated as a frame start, and upstream resets the FIFO with tx_rst.

Configuration
REQ-030: Macro TSMAC_TX_PREAMBLE_EN defined: PRE is compiled in and frames follow REQ-017/018; gmii_tx_en rises 1 clock after IDLE samples rd_empty=0.
REQ-031: Macro TSMAC_TX_PREAMBLE_EN undefined: PRE and PREAMBLE_LEN logic are removed; IDLE with rd_empty=0 pops and transmits the head word directly as in DATA; the FIFO supplies any preamble and SFD bytes.

Verification
REQ-032: Macro on; enqueue 3 words 0x011, 0x022, 0x233 -> 0x55 x7, 0xD5, 0x11, 0x22, 0x33 with gmii_tx_en=1 for 11 clocks, gmii_tx_er=0, and tx_frame_cnt=1.
REQ-033: Two 64-byte frames queued back-to-back, IFG_CYCLES=12 -> exactly 12 gmii_tx_en=0 clocks between the frames, and tx_frame_cnt=2.
REQ-034: FIFO empties after 10 of 20 payload words, then the remaining 10 (last with eof) arrive -> one clock of tx_en=1, tx_er=1, txd=0x00; the 10 late words are drained silently; tx_underrun_cnt=1; tx_frame_cnt=0.
REQ-035: Word 0x1AB mid-frame -> byte 0xAB with gmii_tx_er=1 for that clock only; the frame completes normally.
REQ-036: tx_rst pulsed on payload byte 5 -> gmii_tx_en=0 at the next edge, both counters read 0, and a new frame starts from the next head word.
REQ-037: Macro off; single word 0x2C4 -> one clock of gmii_txd=0xC4 with tx_en=1, then at least 12 idle clocks.

Source files
------------

// File: rtl/tsmac_tx_fifo_reader_if.sv
// ----------------------------------------------------------------------------
// tsmac_tx_fifo_reader_if
// Read-side bundle of the TSMAC transmit FIFO (show-ahead FIFO).
//   rd_data  [9] eof, [8] err, [7:0] byte; valid while rd_empty = 0
//   rd_empty FIFO empty flag
//   rd_en    pops the head word in the cycle it is high
// master : the reader (drives rd_en)
// slave  : the FIFO   (drives rd_data / rd_empty)
// ----------------------------------------------------------------------------
interface tsmac_tx_fifo_reader_if;
   logic [9:0] rd_data;
   logic       rd_empty;
   logic       rd_en;

   modport master (input rd_data, input rd_empty, output rd_en);
   modport slave  (output rd_data, output rd_empty, input rd_en);
endinterface

// File: rtl/tsmac_tx_fifo_reader.sv
// ----------------------------------------------------------------------------
// tsmac_tx_fifo_reader
// Pulls frame words from the TX FIFO and drives them onto GMII, inserting the
// preamble/SFD (optional) and the inter-frame gap. Underruns abort the frame
// with a one-clock error symbol and the rest of that frame is drained.
//
// Ports
//   tx_clk          clock for all logic
//   tx_rst          synchronous active-high reset
//   fifo            TX FIFO read bundle (master side)
//   gmii_txd        transmit byte (registered)
//   gmii_tx_en      transmit enable (registered)
//   gmii_tx_er      transmit error (registered)
//   tx_busy         high in every state except IDLE
//   tx_frame_cnt    completed frames, wraps
//   tx_underrun_cnt underruns, saturates at 16'hFFFF
//
// Configuration macro: TSMAC_TX_PREAMBLE_EN
//   defined   : PREAMBLE_LEN x 0x55 + 0xD5 are generated before the payload
//   undefined : the FIFO supplies preamble/SFD; IDLE transmits the head word
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a head word; GMII outputs held at 0
// PRE   | sending preamble bytes then SFD (TSMAC_TX_PREAMBLE_EN only)
// DATA  | one payload word popped and sent per clock
// DRAIN | after underrun: silently pop until the eof word
// IFG   | gmii_tx_en held low for IFG_CYCLES clocks
// ----------------------------------------------------------------------------
module tsmac_tx_fifo_reader #(
   parameter int unsigned IFG_CYCLES   = 12,
   parameter int unsigned PREAMBLE_LEN = 7
) (
   input  logic                          tx_clk,
   input  logic                          tx_rst,
   tsmac_tx_fifo_reader_if.master        fifo,
   output logic [7:0]                    gmii_txd,
   output logic                          gmii_tx_en,
   output logic                          gmii_tx_er,
   output logic                          tx_busy,
   output logic [15:0]                   tx_frame_cnt,
   output logic [15:0]                   tx_underrun_cnt
);

`ifdef TSMAC_TX_PREAMBLE_EN
   typedef enum logic [2:0] {IDLE, PRE, DATA, DRAIN, IFG} state_t;
   localparam logic [7:0] PRE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE = 8'hD5;
   localparam logic [3:0] PRE_LOAD = 4'(PREAMBLE_LEN - 1);
`else
   typedef enum logic [2:0] {IDLE, DATA, DRAIN, IFG} state_t;
`endif

   // IFG counts down to 0; the IDLE cycle that follows already registers the
   // first byte of the next frame, so IFG_CYCLES low cycles appear on the pins.
   localparam logic [7:0] IFG_LOAD = 8'(IFG_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  txd_q, txd_d;
   logic        en_q, en_d;
   logic        er_q, er_d;
   logic [7:0]  ifg_cnt_q, ifg_cnt_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [15:0] urun_cnt_q, urun_cnt_d;
   logic        pop;
`ifdef TSMAC_TX_PREAMBLE_EN
   logic [3:0]  pre_cnt_q, pre_cnt_d;
`endif

   logic       head_eof;
   logic       head_err;
   logic [7:0] head_byte;

   assign head_eof  = fifo.rd_data[9];
   assign head_err  = fifo.rd_data[8];
   assign head_byte = fifo.rd_data[7:0];

   always_comb begin
      state_d     = state_q;
      txd_d       = 8'h00;
      en_d        = 1'b0;
      er_d        = 1'b0;
      ifg_cnt_d   = ifg_cnt_q;
      frame_cnt_d = frame_cnt_q;
      urun_cnt_d  = urun_cnt_q;
      pop         = 1'b0;
`ifdef TSMAC_TX_PREAMBLE_EN
      pre_cnt_d   = pre_cnt_q;
`endif
      case (state_q)
`ifdef TSMAC_TX_PREAMBLE_EN
         IDLE: begin
            if (!fifo.rd_empty) begin
               state_d   = PRE;
               txd_d     = PRE_BYTE;
               en_d      = 1'b1;
               pre_cnt_d = PRE_LOAD;
            end
         end
         PRE: begin
            en_d = 1'b1;
            if (pre_cnt_q == 4'd0) begin
               txd_d   = SFD_BYTE;
               state_d = DATA;
            end else begin
               txd_d     = PRE_BYTE;
               pre_cnt_d = pre_cnt_q - 4'd1;
            end
         end
         DATA: begin
`else
         IDLE, DATA: begin
`endif
            if (!fifo.rd_empty) begin
               pop   = 1'b1;
               txd_d = head_byte;
               en_d  = 1'b1;
               er_d  = head_err;
               if (head_eof) begin
                  frame_cnt_d = frame_cnt_q + 16'd1;
                  ifg_cnt_d   = IFG_LOAD;
                  state_d     = IFG;
               end else begin
                  state_d = DATA;
               end
            end else if (state_q == DATA) begin
               // underrun: one error symbol, then discard the rest of the frame
               en_d = 1'b1;
               er_d = 1'b1;
               if (urun_cnt_q != 16'hFFFF) begin
                  urun_cnt_d = urun_cnt_q + 16'd1;
               end
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!fifo.rd_empty) begin
               pop = 1'b1;
               if (head_eof) begin
                  ifg_cnt_d = IFG_LOAD;
                  state_d   = IFG;
               end
            end
         end
         IFG: begin
            if (ifg_cnt_q == 8'd0) begin
               state_d = IDLE;
            end else begin
               ifg_cnt_d = ifg_cnt_q - 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge tx_clk) begin
      if (tx_rst) begin
         state_q     <= IDLE;
         txd_q       <= 8'h00;
         en_q        <= 1'b0;
         er_q        <= 1'b0;
         ifg_cnt_q   <= 8'd0;
         frame_cnt_q <= 16'd0;
         urun_cnt_q  <= 16'd0;
`ifdef TSMAC_TX_PREAMBLE_EN
         pre_cnt_q   <= 4'd0;
`endif
      end else begin
         state_q     <= state_d;
         txd_q       <= txd_d;
         en_q        <= en_d;
         er_q        <= er_d;
         ifg_cnt_q   <= ifg_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         urun_cnt_q  <= urun_cnt_d;
`ifdef TSMAC_TX_PREAMBLE_EN
         pre_cnt_q   <= pre_cnt_d;
`endif
      end
   end

   // Parameter legality; ignored by synthesis.
   always_ff @(posedge tx_clk) begin
      assert (IFG_CYCLES >= 2 && IFG_CYCLES <= 255 &&
              PREAMBLE_LEN >= 1 && PREAMBLE_LEN <= 15);
   end

   // Show-ahead FIFO: the pop must be combinational with rd_empty so the word
   // sampled at this edge is the one consumed. pop already implies !rd_empty.
   assign fifo.rd_en      = pop & ~tx_rst;
   assign gmii_txd        = txd_q;
   assign gmii_tx_en      = en_q;
   assign gmii_tx_er      = er_q;
   assign tx_busy         = (state_q != IDLE);
   assign tx_frame_cnt    = frame_cnt_q;
   assign tx_underrun_cnt = urun_cnt_q;

endmodule
